// File: rtl/fft_pkg.sv
// Shared FFT definitions: twiddle format, complex types, the DATA=128 twiddle
// table and the round/saturate helpers used by the twiddle stages.
package fft_pkg;

    localparam int TW_WIDTH    = 9;
    localparam int TW_ONE      = 128;
    localparam int ROUND_SHIFT = 7;
    localparam int DATA_W      = 23;

    typedef struct packed {
        logic signed [TW_WIDTH-1:0] re;
        logic signed [TW_WIDTH-1:0] im;
    } tw_cplx_t;

    typedef struct packed {
        logic signed [DATA_W-1:0] re;
        logic signed [DATA_W-1:0] im;
    } data_cplx_t;

    // round(128*cos(pi*m/128)) for m = 0..64; the full 128-entry table folds onto this quarter wave
    localparam logic [7:0] COS_Q [0:64] = '{
        8'd128, 8'd128, 8'd128, 8'd128, 8'd127, 8'd127, 8'd127, 8'd126,
        8'd126, 8'd125, 8'd124, 8'd123, 8'd122, 8'd122, 8'd121, 8'd119,
        8'd118, 8'd117, 8'd116, 8'd114, 8'd113, 8'd111, 8'd110, 8'd108,
        8'd106, 8'd105, 8'd103, 8'd101, 8'd99,  8'd97,  8'd95,  8'd93,
        8'd91,  8'd88,  8'd86,  8'd84,  8'd81,  8'd79,  8'd76,  8'd74,
        8'd71,  8'd68,  8'd66,  8'd63,  8'd60,  8'd58,  8'd55,  8'd52,
        8'd49,  8'd46,  8'd43,  8'd40,  8'd37,  8'd34,  8'd31,  8'd28,
        8'd25,  8'd22,  8'd19,  8'd16,  8'd13,  8'd9,   8'd6,   8'd3,
        8'd0
    };

    function automatic tw_cplx_t twiddle(input logic [6:0] k);
        tw_cplx_t   w;
        logic [6:0] ci;
        logic [6:0] si;
        logic       neg;
        if (k <= 7'd64) begin
            ci  = k;
            si  = 7'd64 - k;
            neg = 1'b0;
        end else begin
            ci  = 7'd0 - k;
            si  = k - 7'd64;
            neg = 1'b1;
        end
        w.re = neg ? -$signed({1'b0, COS_Q[ci]}) : $signed({1'b0, COS_Q[ci]});
        w.im = -$signed({1'b0, COS_Q[si]});
        return w;
    endfunction

    function automatic logic signed [63:0] sat_to(input logic signed [63:0] v,
                                                  input int out_width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (out_width - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end else begin
            return v;
        end
    endfunction

    function automatic logic signed [63:0] sat_round(input logic signed [63:0] v,
                                                     input int out_width);
        logic signed [63:0] r;
        r = (v + (64'sd1 <<< (ROUND_SHIFT - 1))) >>> ROUND_SHIFT;
        return sat_to(r, out_width);
    endfunction

endpackage

// File: rtl/cmul_round.sv
// One lane of the twiddle multiply: partial products (S2), then combine,
// round-half-up by 2^7 and saturate (S3). Both stages hold when not enabled.
module cmul_round
    import fft_pkg::*;
#(
    parameter int IN_WIDTH  = 23,
    parameter int OUT_WIDTH = 23
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en_s2_i,
    input  logic                        en_s3_i,
    input  logic signed [IN_WIDTH-1:0]  ar_i,
    input  logic signed [IN_WIDTH-1:0]  ai_i,
    input  logic signed [TW_WIDTH-1:0]  wr_i,
    input  logic signed [TW_WIDTH-1:0]  wi_i,
    output logic signed [OUT_WIDTH-1:0] pr_o,
    output logic signed [OUT_WIDTH-1:0] pi_o
);

    localparam int PW = IN_WIDTH + TW_WIDTH;

    logic signed [PW-1:0]        rr_d, ii_d, ri_d, ir_d;
    logic signed [PW-1:0]        rr_q, ii_q, ri_q, ir_q;
    logic signed [PW:0]          pre_re_d, pre_im_d;
    logic signed [OUT_WIDTH-1:0] pr_d, pi_d;

    always_comb begin
        rr_d     = PW'(ar_i) * PW'(wr_i);
        ii_d     = PW'(ai_i) * PW'(wi_i);
        ri_d     = PW'(ar_i) * PW'(wi_i);
        ir_d     = PW'(ai_i) * PW'(wr_i);
        pre_re_d = (PW+1)'(rr_q) - (PW+1)'(ii_q);
        pre_im_d = (PW+1)'(ri_q) + (PW+1)'(ir_q);
        pr_d     = OUT_WIDTH'(sat_round(64'(pre_re_d), OUT_WIDTH));
        pi_d     = OUT_WIDTH'(sat_round(64'(pre_im_d), OUT_WIDTH));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_q <= {PW{1'b0}};
            ii_q <= {PW{1'b0}};
            ri_q <= {PW{1'b0}};
            ir_q <= {PW{1'b0}};
            pr_o <= {OUT_WIDTH{1'b0}};
            pi_o <= {OUT_WIDTH{1'b0}};
        end else begin
            if (en_s2_i) begin
                rr_q <= rr_d;
                ii_q <= ii_d;
                ri_q <= ri_d;
                ir_q <= ir_d;
            end
            if (en_s3_i) begin
                pr_o <= pr_d;
                pi_o <= pi_d;
            end
        end
    end

endmodule

// File: rtl/twiddle_mul02.sv
// Twiddle stage after butterfly02: counts beats, looks up W(b*NUM+j) per lane,
// multiplies the difference path and delay-matches the sum path (latency 3).
module twiddle_mul02
    import fft_pkg::*;
#(
    parameter int IN_WIDTH  = 23,
    parameter int OUT_WIDTH = 23,
    parameter int NUM       = 16,
    parameter int DATA      = 128,
    localparam int BW       = $clog2(DATA / NUM)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic signed [IN_WIDTH-1:0]  din1_re [NUM],
    input  logic signed [IN_WIDTH-1:0]  din1_im [NUM],
    input  logic signed [IN_WIDTH-1:0]  din2_re [NUM],
    input  logic signed [IN_WIDTH-1:0]  din2_im [NUM],
    input  logic                        valid_in,
    output logic signed [OUT_WIDTH-1:0] dout1_re [NUM],
    output logic signed [OUT_WIDTH-1:0] dout1_im [NUM],
    output logic signed [OUT_WIDTH-1:0] dout2_re [NUM],
    output logic signed [OUT_WIDTH-1:0] dout2_im [NUM],
    output logic                        valid_out,
    output logic [BW-1:0]               beat_idx
);

    localparam int KW = $clog2(DATA);

    logic [BW-1:0]               b_q, b_d, b1_q, b2_q;
    logic                        v1_q, v2_q;
    logic signed [IN_WIDTH-1:0]  d1re_s1_q [NUM];
    logic signed [IN_WIDTH-1:0]  d1im_s1_q [NUM];
    logic signed [IN_WIDTH-1:0]  d2re_s1_q [NUM];
    logic signed [IN_WIDTH-1:0]  d2im_s1_q [NUM];
    logic signed [IN_WIDTH-1:0]  d1re_s2_q [NUM];
    logic signed [IN_WIDTH-1:0]  d1im_s2_q [NUM];
    tw_cplx_t                    tw_d [NUM];
    tw_cplx_t                    tw_q [NUM];

    // beat counter advances only on qualified beats so gaps keep the twiddle mapping
    always_comb begin
        b_d = b_q;
        if (valid_in) begin
            if (b_q == BW'(DATA / NUM - 1)) begin
                b_d = {BW{1'b0}};
            end else begin
                b_d = b_q + BW'(1);
            end
        end else begin
            b_d = b_q;
        end
        for (int j = 0; j < NUM; j++) begin
            tw_d[j] = twiddle(KW'(int'(b_q) * NUM + j));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b_q       <= {BW{1'b0}};
            b1_q      <= {BW{1'b0}};
            b2_q      <= {BW{1'b0}};
            beat_idx  <= {BW{1'b0}};
            v1_q      <= 1'b0;
            v2_q      <= 1'b0;
            valid_out <= 1'b0;
        end else begin
            b_q       <= b_d;
            v1_q      <= valid_in;
            v2_q      <= v1_q;
            valid_out <= v2_q;
            if (valid_in) b1_q <= b_q;
            if (v1_q)     b2_q <= b1_q;
            if (v2_q)     beat_idx <= b2_q;
        end
    end

    // S1 capture plus the two remaining sum-path stages; every stage holds when idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < NUM; j++) begin
                d1re_s1_q[j] <= {IN_WIDTH{1'b0}};
                d1im_s1_q[j] <= {IN_WIDTH{1'b0}};
                d2re_s1_q[j] <= {IN_WIDTH{1'b0}};
                d2im_s1_q[j] <= {IN_WIDTH{1'b0}};
                d1re_s2_q[j] <= {IN_WIDTH{1'b0}};
                d1im_s2_q[j] <= {IN_WIDTH{1'b0}};
                tw_q[j]      <= {2 * TW_WIDTH{1'b0}};
                dout1_re[j]  <= {OUT_WIDTH{1'b0}};
                dout1_im[j]  <= {OUT_WIDTH{1'b0}};
            end
        end else begin
            for (int j = 0; j < NUM; j++) begin
                if (valid_in) begin
                    d1re_s1_q[j] <= din1_re[j];
                    d1im_s1_q[j] <= din1_im[j];
                    d2re_s1_q[j] <= din2_re[j];
                    d2im_s1_q[j] <= din2_im[j];
                    tw_q[j]      <= tw_d[j];
                end
                if (v1_q) begin
                    d1re_s2_q[j] <= d1re_s1_q[j];
                    d1im_s2_q[j] <= d1im_s1_q[j];
                end
                if (v2_q) begin
                    dout1_re[j] <= OUT_WIDTH'(sat_to(64'(d1re_s2_q[j]), OUT_WIDTH));
                    dout1_im[j] <= OUT_WIDTH'(sat_to(64'(d1im_s2_q[j]), OUT_WIDTH));
                end
            end
        end
    end

    for (genvar j = 0; j < NUM; j++) begin : g_lane
        cmul_round #(
            .IN_WIDTH (IN_WIDTH),
            .OUT_WIDTH(OUT_WIDTH)
        ) u_cmul (
            .clk    (clk),
            .rst    (rst),
            .en_s2_i(v1_q),
            .en_s3_i(v2_q),
            .ar_i   (d2re_s1_q[j]),
            .ai_i   (d2im_s1_q[j]),
            .wr_i   (tw_q[j].re),
            .wi_i   (tw_q[j].im),
            .pr_o   (dout2_re[j]),
            .pi_o   (dout2_im[j])
        );
    end

endmodule

// File: tb/tb_twiddle_mul02.sv
// Bench for twiddle_mul02: a cycle model built from trig-computed twiddles and
// real-valued rounding, checked every cycle, plus literal spot checks.
module tb_twiddle_mul02;

    localparam int IW = 23;
    localparam int OW = 23;
    localparam int N  = 16;
    localparam int D  = 128;
    localparam int NB = D / N;
    localparam real PI = 3.14159265358979323846;

    logic clk = 1'b0;
    logic rst;
    logic valid_in;
    logic signed [IW-1:0] din1_re [N];
    logic signed [IW-1:0] din1_im [N];
    logic signed [IW-1:0] din2_re [N];
    logic signed [IW-1:0] din2_im [N];
    logic signed [OW-1:0] dout1_re [N];
    logic signed [OW-1:0] dout1_im [N];
    logic signed [OW-1:0] dout2_re [N];
    logic signed [OW-1:0] dout2_im [N];
    logic valid_out;
    logic [2:0] beat_idx;

    int compared   = 0;
    int mismatched = 0;

    typedef struct packed {
        logic [2:0]      beat;
        logic [N*OW-1:0] r1;
        logic [N*OW-1:0] i1;
        logic [N*OW-1:0] r2;
        logic [N*OW-1:0] i2;
    } exp_t;

    exp_t exp_q[$];
    exp_t exp_cur;
    exp_t e_tmp;
    bit   ev0, ev1, ev2;
    int   mb;

    always #5 clk = ~clk;

    twiddle_mul02 #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .NUM(N), .DATA(D)) dut (
        .clk(clk), .rst(rst),
        .din1_re(din1_re), .din1_im(din1_im), .din2_re(din2_re), .din2_im(din2_im),
        .valid_in(valid_in),
        .dout1_re(dout1_re), .dout1_im(dout1_im), .dout2_re(dout2_re), .dout2_im(dout2_im),
        .valid_out(valid_out), .beat_idx(beat_idx)
    );

    task automatic chk(input string nm, input int lane, input logic signed [63:0] act,
                       input logic signed [63:0] want);
        compared++;
        if (act !== want) begin
            mismatched++;
            $display("FAIL %s lane %0d at %0t: got %0d, want %0d", nm, lane, $time, act, want);
        end
    endtask

    function automatic int rnd_away(input real x);
        if (x >= 0.0) return $rtoi($floor(x + 0.5));
        else          return -$rtoi($floor(-x + 0.5));
    endfunction

    function automatic int tw_re(input int k);
        return rnd_away(128.0 * $cos(PI * k / 128.0));
    endfunction

    function automatic int tw_im(input int k);
        return -rnd_away(128.0 * $sin(PI * k / 128.0));
    endfunction

    function automatic int round_sat(input int p);
        real x;
        int  r;
        x = p;
        r = $rtoi($floor(x / 128.0 + 0.5));
        if (r > 4194303)  r = 4194303;
        if (r < -4194304) r = -4194304;
        return r;
    endfunction

    // model at each rising edge, compare at each falling edge
    initial begin
        int ar, ai, wr, wi, k;
        ev0 = 1'b0; ev1 = 1'b0; ev2 = 1'b0; mb = 0; exp_cur = '0;
        forever begin
            @(posedge clk);
            if (rst) begin
                ev0 = 1'b0; ev1 = 1'b0; ev2 = 1'b0; mb = 0;
                exp_q.delete();
                exp_cur = '0;
            end else begin
                ev2 = ev1; ev1 = ev0; ev0 = valid_in;
                if (valid_in) begin
                    e_tmp.beat = 3'(mb);
                    for (int j = 0; j < N; j++) begin
                        k  = mb * N + j;
                        ar = din2_re[j]; ai = din2_im[j];
                        wr = tw_re(k);   wi = tw_im(k);
                        e_tmp.r1[j*OW +: OW] = din1_re[j];
                        e_tmp.i1[j*OW +: OW] = din1_im[j];
                        e_tmp.r2[j*OW +: OW] = OW'(round_sat(ar * wr - ai * wi));
                        e_tmp.i2[j*OW +: OW] = OW'(round_sat(ar * wi + ai * wr));
                    end
                    exp_q.push_back(e_tmp);
                    mb = (mb + 1) % NB;
                end
                if (ev2 && exp_q.size() > 0) exp_cur = exp_q.pop_front();
            end
            @(negedge clk);
            if (rst) begin
                chk("valid_out", 0, 64'(valid_out), 64'sd0);
                chk("beat_idx", 0, 64'(beat_idx), 64'sd0);
                for (int j = 0; j < N; j++) begin
                    chk("dout1_re", j, 64'(dout1_re[j]), 64'sd0);
                    chk("dout1_im", j, 64'(dout1_im[j]), 64'sd0);
                    chk("dout2_re", j, 64'(dout2_re[j]), 64'sd0);
                    chk("dout2_im", j, 64'(dout2_im[j]), 64'sd0);
                end
            end else begin
                chk("valid_out", 0, 64'(valid_out), 64'(ev2));
                if (ev2) chk("beat_idx", 0, 64'(beat_idx), 64'(exp_cur.beat));
                for (int j = 0; j < N; j++) begin
                    chk("dout1_re", j, 64'(dout1_re[j]), 64'($signed(exp_cur.r1[j*OW +: OW])));
                    chk("dout1_im", j, 64'(dout1_im[j]), 64'($signed(exp_cur.i1[j*OW +: OW])));
                    chk("dout2_re", j, 64'(dout2_re[j]), 64'($signed(exp_cur.r2[j*OW +: OW])));
                    chk("dout2_im", j, 64'(dout2_im[j]), 64'($signed(exp_cur.i2[j*OW +: OW])));
                end
            end
        end
    end

    task automatic step(input bit v);
        @(posedge clk);
        #1 valid_in = v;
    endtask

    task automatic rand_data();
        for (int j = 0; j < N; j++) begin
            din1_re[j] = IW'($urandom);
            din1_im[j] = IW'($urandom);
            din2_re[j] = IW'($urandom);
            din2_im[j] = IW'($urandom);
        end
    endtask

    initial begin
        rst = 1'b1;
        valid_in = 1'b0;
        for (int j = 0; j < N; j++) begin
            din1_re[j] = '0; din1_im[j] = '0; din2_re[j] = '0; din2_im[j] = '0;
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("lit_reset_valid", 0, 64'(valid_out), 64'sd0);
        chk("lit_reset_dout2", 0, 64'(dout2_re[0]), 64'sd0);

        // beat 0: identity twiddle
        step(1'b1); rand_data(); din2_re[0] = 23'sd1000; din2_im[0] = -23'sd2000;
        step(1'b0); step(1'b0);
        #1 chk("lit_latency_valid_early", 0, 64'(valid_out), 64'sd0);
        step(1'b0);
        #1;
        chk("lit_identity_re", 0, 64'(dout2_re[0]), 64'sd1000);
        chk("lit_identity_im", 0, 64'(dout2_im[0]), -64'sd2000);
        chk("lit_identity_valid", 0, 64'(valid_out), 64'sd1);
        chk("lit_identity_beat", 0, 64'(beat_idx), 64'sd0);

        // beats 1..4: saturation at k=32, quarter rotation at k=64
        step(1'b1); rand_data();
        step(1'b1); rand_data();
        din2_re[0] = 23'sd4194303; din2_im[0] = 23'sd4194303;
        din1_re[0] = -23'sd4194304; din1_im[0] = 23'sd4194303;
        step(1'b1); rand_data();
        step(1'b1); rand_data(); din2_re[0] = 23'sd300; din2_im[0] = 23'sd700;
        step(1'b0);
        #1;
        chk("lit_sat_re", 0, 64'(dout2_re[0]), 64'sd4194303);
        chk("lit_sat_im", 0, 64'(dout2_im[0]), 64'sd0);
        chk("lit_sat_sum_re", 0, 64'(dout1_re[0]), -64'sd4194304);
        chk("lit_sat_sum_im", 0, 64'(dout1_im[0]), 64'sd4194303);
        step(1'b0); step(1'b0);
        #1;
        chk("lit_quarter_re", 0, 64'(dout2_re[0]), 64'sd700);
        chk("lit_quarter_im", 0, 64'(dout2_im[0]), -64'sd300);
        chk("lit_quarter_beat", 0, 64'(beat_idx), 64'sd4);
        repeat (3) begin step(1'b1); rand_data(); end

        // framing: gap after beat 3, then a 3-cycle gap between frames
        for (int b = 0; b < NB; b++) begin
            step(1'b1); rand_data();
            if (b == 3) begin step(1'b0); step(1'b0); end
        end
        repeat (3) step(1'b0);
        repeat (NB) begin step(1'b1); rand_data(); end

        // reset mid-stream with valid_in still asserted
        repeat (5) begin step(1'b1); rand_data(); end
        step(1'b1); rand_data(); rst = 1'b1;
        #1;
        chk("lit_midrst_valid", 0, 64'(valid_out), 64'sd0);
        chk("lit_midrst_dout1", 3, 64'(dout1_re[3]), 64'sd0);
        step(1'b1); rand_data();
        step(1'b1); rand_data(); rst = 1'b0;
        step(1'b0); step(1'b0); step(1'b0);
        #1;
        chk("lit_postrst_valid", 0, 64'(valid_out), 64'sd1);
        chk("lit_postrst_beat", 0, 64'(beat_idx), 64'sd0);

        // two full frames back to back of random data
        repeat (2 * NB) begin step(1'b1); rand_data(); end
        repeat (6) step(1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
